// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter
// Shares rom_C, rom_Occ and rom_read_and_D between two fetch stages.
// One requester is granted per cycle (round-robin on ties). The winner's
// ROM enables and addresses are registered straight onto the ROM ports.
// A tag pipeline follows each read through the ROM and raises the owner's
// rvalid in the cycle the ROM output data is valid.
module rom_access_arbiter #(
  parameter int ROM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  // requester 0
  input  logic        req0,
  input  logic        ce_C_0,
  input  logic        ce_Occ_0,
  input  logic        ce_D_0,
  input  logic [1:0]  addr_C_0,
  input  logic [7:0]  addr1_Occ_0,
  input  logic [7:0]  addr2_Occ_0,
  input  logic [7:0]  addr_D_0,
  // requester 1
  input  logic        req1,
  input  logic        ce_C_1,
  input  logic        ce_Occ_1,
  input  logic        ce_D_1,
  input  logic [1:0]  addr_C_1,
  input  logic [7:0]  addr1_Occ_1,
  input  logic [7:0]  addr2_Occ_1,
  input  logic [7:0]  addr_D_1,
  // grant / read-valid handshake
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  // shared read data
  output logic [7:0]  d_i,
  output logic [1:0]  read_i,
  output logic [31:0] data_1,
  output logic [31:0] data_2,
  output logic [7:0]  data,
  // ROM side
  output logic        ce_rom_C,
  output logic        ce_rom_Occ,
  output logic        ce_rom_read_and_D,
  output logic [1:0]  addr_rom_C,
  output logic [7:0]  addr1_rom_Occ,
  output logic [7:0]  addr2_rom_Occ,
  output logic [7:0]  addr_rom_read_and_D,
  input  logic [7:0]  d_i_rom,
  input  logic [1:0]  read_i_rom,
  input  logic [31:0] data_1_rom,
  input  logic [31:0] data_2_rom,
  input  logic [7:0]  data_rom,
  output logic        busy
);

  // Requester id of the most recent grant; 1 after reset so that
  // requester 0 wins the first tie.
  logic last_winner;
  logic elig0, elig1;
  logic win0, win1;

  // Tag pipeline. Stage 0 lines up with the registered ROM ce/address
  // (the cycle the ROM samples them); stage ROM_LAT lines up with the ROM
  // output data. Hence ROM_LAT+1 entries.
  logic tag_vld_p [0:ROM_LAT];
  logic tag_id_p  [0:ROM_LAT];

  // Arbitration: a request still high during its own grant cycle has
  // already been served and only competes again from the next cycle.
  always_comb begin
    elig0 = req0 & ~gnt0;
    elig1 = req1 & ~gnt1;
    win0  = 1'b0;
    win1  = 1'b0;
    if (en) begin
      if (elig0 && elig1) begin
        win0 = last_winner;
        win1 = ~last_winner;
      end else begin
        win0 = elig0;
        win1 = elig1;
      end
    end
  end

  // Grant pulses and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      last_winner <= 1'b1;
    end else begin
      gnt0 <= win0;
      gnt1 <= win1;
      if (win0)
        last_winner <= 1'b0;
      else if (win1)
        last_winner <= 1'b1;
    end
  end

  // ---- stage p0: ROM ce/address registers ----
  // The winner's fields pass through unmodified (a ce of 0 included); with
  // no grant the ROM ports are parked at all-zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ce_rom_C            <= 1'b0;
      ce_rom_Occ          <= 1'b0;
      ce_rom_read_and_D   <= 1'b0;
      addr_rom_C          <= 2'd0;
      addr1_rom_Occ       <= 8'd0;
      addr2_rom_Occ       <= 8'd0;
      addr_rom_read_and_D <= 8'd0;
    end else if (win0) begin
      ce_rom_C            <= ce_C_0;
      ce_rom_Occ          <= ce_Occ_0;
      ce_rom_read_and_D   <= ce_D_0;
      addr_rom_C          <= addr_C_0;
      addr1_rom_Occ       <= addr1_Occ_0;
      addr2_rom_Occ       <= addr2_Occ_0;
      addr_rom_read_and_D <= addr_D_0;
    end else if (win1) begin
      ce_rom_C            <= ce_C_1;
      ce_rom_Occ          <= ce_Occ_1;
      ce_rom_read_and_D   <= ce_D_1;
      addr_rom_C          <= addr_C_1;
      addr1_rom_Occ       <= addr1_Occ_1;
      addr2_rom_Occ       <= addr2_Occ_1;
      addr_rom_read_and_D <= addr_D_1;
    end else begin
      ce_rom_C            <= 1'b0;
      ce_rom_Occ          <= 1'b0;
      ce_rom_read_and_D   <= 1'b0;
      addr_rom_C          <= 2'd0;
      addr1_rom_Occ       <= 8'd0;
      addr2_rom_Occ       <= 8'd0;
      addr_rom_read_and_D <= 8'd0;
    end
  end

  // ---- stages p1..pROM_LAT: tag shift toward the ROM data output ----
  // Reset clears every tag, so reads in flight at reset never report.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= ROM_LAT; i++) begin
        tag_vld_p[i] <= 1'b0;
        tag_id_p[i]  <= 1'b0;
      end
    end else begin
      tag_vld_p[0] <= win0 | win1;
      tag_id_p[0]  <= win1;
      for (int i = 1; i <= ROM_LAT; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
        tag_id_p[i]  <= tag_id_p[i-1];
      end
    end
  end

  // Busy while any tag is still travelling alongside a ROM read.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= ROM_LAT; i++)
      busy = busy | tag_vld_p[i];
  end

  // Read-valid decode from the last tag stage, aligned with the ROM data.
  assign rvalid0 = tag_vld_p[ROM_LAT] & ~tag_id_p[ROM_LAT];
  assign rvalid1 = tag_vld_p[ROM_LAT] &  tag_id_p[ROM_LAT];

  // Shared read data goes straight from the ROMs to both requesters.
  assign d_i    = d_i_rom;
  assign read_i = read_i_rom;
  assign data_1 = data_1_rom;
  assign data_2 = data_2_rom;
  assign data   = data_rom;

endmodule
